tl_rx_fc_rcv_credit_tracker: RTL and testbench



---
 rtl/tl_rx_fc_rcv_credit_tracker.sv | 136 +++++++++++++
 tb/tb_tl_rx_fc_rcv_credit_tracker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_rx_fc_rcv_credit_tracker.sv
// Sequences one TLP descriptor at a time through the receiver-overflow checker and
// keeps the P/NP/CPL header and data credits-received counters for accepted TLPs.
module tl_rx_fc_rcv_credit_tracker #(
  parameter int unsigned BUFFER_IN_DW_WIDTH   = 10,
  parameter int unsigned RCV_HDR_CREDS_WIDTH  = 12,
  parameter int unsigned RCV_DATA_CREDS_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tlp_valid,
  output logic                            tlp_ready,
  input  logic [1:0]                      tlp_typ,
  input  logic                            tlp_has_data,
  input  logic [BUFFER_IN_DW_WIDTH-1:0]   tlp_len_dw,
  input  logic                            receiver_overflow_error,
  output logic [1:0]                      buffer_typ,
  output logic [BUFFER_IN_DW_WIDTH-1:0]   buffer_in,
  output logic                            receiver_overflow_en,
  output logic [RCV_HDR_CREDS_WIDTH-1:0]  p_rcv_hdr,
  output logic [RCV_HDR_CREDS_WIDTH-1:0]  np_rcv_hdr,
  output logic [RCV_HDR_CREDS_WIDTH-1:0]  cpl_rcv_hdr,
  output logic [RCV_DATA_CREDS_WIDTH-1:0] p_rcv_data,
  output logic [RCV_DATA_CREDS_WIDTH-1:0] np_rcv_data,
  output logic [RCV_DATA_CREDS_WIDTH-1:0] cpl_rcv_data,
  output logic                            tlp_done,
  output logic                            tlp_dropped
);

  localparam int unsigned LenW = BUFFER_IN_DW_WIDTH;
  localparam int unsigned HdrW = RCV_HDR_CREDS_WIDTH;
  localparam int unsigned DatW = RCV_DATA_CREDS_WIDTH;

  localparam logic [1:0] TypInv = 2'b11;

  typedef enum logic [1:0] {StIdle, StCheck, StCommit} state_e;

  state_e            state_q, state_d;
  logic [1:0]        typ_q, typ_d;
  logic              has_data_q, has_data_d;
  logic [LenW-1:0]   len_q, len_d;
  logic              drop_q, drop_d;
  logic              commit_en;

  logic [HdrW-1:0]   hdr_q  [3];
  logic [DatW-1:0]   data_q [3];

  // A zero length with payload encodes 2^LenW DW, hence the extra top bit.
  logic [LenW:0]     len_ext;
  logic [LenW+1:0]   len_round;
  logic [DatW-1:0]   data_creds;

  assign len_ext    = {has_data_q && (len_q == '0), len_q};
  assign len_round  = {1'b0, len_ext} + (LenW + 2)'(3);
  assign data_creds = has_data_q ? DatW'(len_round[LenW+1:2]) : '0;

  always_comb begin
    state_d              = state_q;
    typ_d                = typ_q;
    has_data_d           = has_data_q;
    len_d                = len_q;
    drop_d               = drop_q;
    tlp_ready            = 1'b0;
    buffer_typ           = TypInv;
    buffer_in            = '0;
    receiver_overflow_en = 1'b0;
    tlp_done             = 1'b0;
    tlp_dropped          = 1'b0;
    commit_en            = 1'b0;
    unique case (state_q)
      StIdle: begin
        tlp_ready = 1'b1;
        if (tlp_valid) begin
          typ_d      = tlp_typ;
          has_data_d = tlp_has_data;
          len_d      = tlp_len_dw;
          drop_d     = (tlp_typ == TypInv);
          state_d    = (tlp_typ == TypInv) ? StCommit : StCheck;
        end
      end
      StCheck: begin
        buffer_typ           = typ_q;
        buffer_in            = has_data_q ? len_q : '0;
        receiver_overflow_en = 1'b1;
        drop_d               = receiver_overflow_error;
        state_d              = StCommit;
      end
      StCommit: begin
        tlp_done    = 1'b1;
        tlp_dropped = drop_q;
        commit_en   = !drop_q && (typ_q != TypInv);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      typ_q      <= TypInv;
      has_data_q <= 1'b0;
      len_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      typ_q      <= typ_d;
      has_data_q <= has_data_d;
      len_q      <= len_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        hdr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (commit_en && (typ_q == 2'(i))) begin
          hdr_q[i]  <= hdr_q[i] + HdrW'(1);
          data_q[i] <= data_q[i] + data_creds;
        end
      end
    end
  end

  assign p_rcv_hdr    = hdr_q[0];
  assign np_rcv_hdr   = hdr_q[1];
  assign cpl_rcv_hdr  = hdr_q[2];
  assign p_rcv_data   = data_q[0];
  assign np_rcv_data  = data_q[1];
  assign cpl_rcv_data = data_q[2];

endmodule

// File: tb/tb_tl_rx_fc_rcv_credit_tracker.sv
// Randomized scoreboard bench: the driver queues expected checker requests and completions,
// a negedge monitor pops and compares them against what the tracker presents.
module tb_tl_rx_fc_rcv_credit_tracker;

  localparam int LW = 10;
  localparam int HW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tlp_valid;
  logic          tlp_ready;
  logic [1:0]    tlp_typ;
  logic          tlp_has_data;
  logic [LW-1:0] tlp_len_dw;
  logic          receiver_overflow_error;
  logic [1:0]    buffer_typ;
  logic [LW-1:0] buffer_in;
  logic          receiver_overflow_en;
  logic [HW-1:0] p_rcv_hdr, np_rcv_hdr, cpl_rcv_hdr;
  logic [DW-1:0] p_rcv_data, np_rcv_data, cpl_rcv_data;
  logic          tlp_done;
  logic          tlp_dropped;

  tl_rx_fc_rcv_credit_tracker #(
    .BUFFER_IN_DW_WIDTH  (LW),
    .RCV_HDR_CREDS_WIDTH (HW),
    .RCV_DATA_CREDS_WIDTH(DW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .tlp_valid              (tlp_valid),
    .tlp_ready              (tlp_ready),
    .tlp_typ                (tlp_typ),
    .tlp_has_data           (tlp_has_data),
    .tlp_len_dw             (tlp_len_dw),
    .receiver_overflow_error(receiver_overflow_error),
    .buffer_typ             (buffer_typ),
    .buffer_in              (buffer_in),
    .receiver_overflow_en   (receiver_overflow_en),
    .p_rcv_hdr              (p_rcv_hdr),
    .np_rcv_hdr             (np_rcv_hdr),
    .cpl_rcv_hdr            (cpl_rcv_hdr),
    .p_rcv_data             (p_rcv_data),
    .np_rcv_data            (np_rcv_data),
    .cpl_rcv_data           (cpl_rcv_data),
    .tlp_done               (tlp_done),
    .tlp_dropped            (tlp_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    typ;
    logic [LW-1:0] len;
  } chk_exp_t;

  typedef struct packed {
    logic           dropped;
    logic [1:0]     lat;
    logic [3*HW-1:0] hdr;
    logic [3*DW-1:0] data;
  } done_exp_t;

  chk_exp_t    chk_q[$];
  done_exp_t   done_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned m_hdr[3];
  int unsigned m_data[3];
  int          ncyc = 0;
  int          acc_cyc = 0;
  bit          cnt_pend = 0;
  done_exp_t   cnt_exp;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not expected or not seen at %0t", name, $time);
  endtask

  function automatic int unsigned credits(input bit hd, input int unsigned len);
    int unsigned n;
    if (!hd) return 0;
    n = (len == 0) ? (1 << LW) : len;
    return (n + 3) / 4;
  endfunction

  function automatic done_exp_t snapshot(input bit dropped, input int lat);
    done_exp_t e;
    e.dropped = dropped;
    e.lat     = 2'(lat);
    e.hdr     = {HW'(m_hdr[2]), HW'(m_hdr[1]), HW'(m_hdr[0])};
    e.data    = {DW'(m_data[2]), DW'(m_data[1]), DW'(m_data[0])};
    return e;
  endfunction

  // Monitor: decoupled from the driver, compares whatever the DUT presents.
  always @(negedge clk) begin
    chk_exp_t  ce;
    done_exp_t de;
    if (rst) begin
      cnt_pend = 0;
    end else begin
      ncyc++;
      if (cnt_pend) begin
        cnt_pend = 0;
        check("p_rcv_hdr",    p_rcv_hdr,    cnt_exp.hdr[0*HW +: HW]);
        check("np_rcv_hdr",   np_rcv_hdr,   cnt_exp.hdr[1*HW +: HW]);
        check("cpl_rcv_hdr",  cpl_rcv_hdr,  cnt_exp.hdr[2*HW +: HW]);
        check("p_rcv_data",   p_rcv_data,   cnt_exp.data[0*DW +: DW]);
        check("np_rcv_data",  np_rcv_data,  cnt_exp.data[1*DW +: DW]);
        check("cpl_rcv_data", cpl_rcv_data, cnt_exp.data[2*DW +: DW]);
      end
      if (tlp_valid && tlp_ready) acc_cyc = ncyc;
      if (receiver_overflow_en) begin
        if (chk_q.size() == 0) begin
          flag("unexpected_overflow_en");
        end else begin
          ce = chk_q.pop_front();
          check("check_buffer_typ", buffer_typ, ce.typ);
          check("check_buffer_in", buffer_in, ce.len);
          check("check_latency", ncyc - acc_cyc, 1);
        end
      end else begin
        check("idle_buffer_typ", buffer_typ, 2'b11);
        check("idle_buffer_in", buffer_in, 0);
      end
      if (tlp_done) begin
        if (done_q.size() == 0) begin
          flag("unexpected_tlp_done");
        end else begin
          de = done_q.pop_front();
          check("tlp_dropped", tlp_dropped, de.dropped);
          check("done_latency", ncyc - acc_cyc, de.lat);
          check("ready_in_done", tlp_ready, 0);
          cnt_exp  = de;
          cnt_pend = 1;
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!tlp_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!tlp_ready) flag("ready_timeout");
  endtask

  task automatic drain();
    int k = 0;
    while ((done_q.size() != 0 || chk_q.size() != 0 || cnt_pend) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (done_q.size() != 0 || chk_q.size() != 0) flag("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] typ, input bit hd, input int unsigned len, input bit err);
    bit drop;
    wait_ready();
    tlp_valid               = 1'b1;
    tlp_typ                 = typ;
    tlp_has_data            = hd;
    tlp_len_dw              = LW'(len);
    receiver_overflow_error = err;
    drop = (typ == 2'b11) || err;
    if (typ != 2'b11) chk_q.push_back('{typ: typ, len: hd ? LW'(len) : '0});
    if (!drop) begin
      m_hdr[typ]  = (m_hdr[typ] + 1) % (1 << HW);
      m_data[typ] = (m_data[typ] + credits(hd, len)) % (1 << DW);
    end
    done_q.push_back(snapshot(drop, (typ == 2'b11) ? 1 : 2));
    @(posedge clk);
    #1;
    tlp_valid    = 1'b0;
    tlp_typ      = 2'($urandom);
    tlp_has_data = 1'($urandom);
    tlp_len_dw   = LW'($urandom);
    @(posedge clk);
    #1;
    // Outside CHECK the error input must have no effect.
    receiver_overflow_error = 1'($urandom);
  endtask

  task automatic check_counters_zero(input string tag);
    check({tag, "_p_hdr"},   p_rcv_hdr,    0);
    check({tag, "_np_hdr"},  np_rcv_hdr,   0);
    check({tag, "_cpl_hdr"}, cpl_rcv_hdr,  0);
    check({tag, "_p_dat"},   p_rcv_data,   0);
    check({tag, "_np_dat"},  np_rcv_data,  0);
    check({tag, "_cpl_dat"}, cpl_rcv_data, 0);
  endtask

  initial begin
    rst                     = 1'b1;
    tlp_valid               = 1'b0;
    tlp_typ                 = 2'b00;
    tlp_has_data            = 1'b0;
    tlp_len_dw              = '0;
    receiver_overflow_error = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_hdr[i]  = 0;
      m_data[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_counters_zero("reset");
    check("reset_ready", tlp_ready, 1);
    check("reset_done", tlp_done, 0);
    check("reset_dropped", tlp_dropped, 0);
    check("reset_en", receiver_overflow_en, 0);
    check("reset_buffer_typ", buffer_typ, 2'b11);
    check("reset_buffer_in", buffer_in, 0);
    rst = 1'b0;

    // Directed cases
    send(2'b00, 1, 5, 0);
    drain();
    check("dir_p_hdr", p_rcv_hdr, 1);
    check("dir_p_data", p_rcv_data, 2);
    send(2'b01, 0, 300, 0);
    drain();
    check("dir_np_hdr", np_rcv_hdr, 1);
    check("dir_np_data", np_rcv_data, 0);
    send(2'b10, 1, 0, 0);
    drain();
    check("dir_cpl_data", cpl_rcv_data, 256);
    send(2'b00, 1, 8, 1);
    send(2'b11, 1, 7, 0);
    drain();
    check("dir_p_hdr_after_drop", p_rcv_hdr, 1);
    check("dir_p_data_after_drop", p_rcv_data, 2);

    // Reset while the descriptor is in CHECK: no completion, counters cleared
    wait_ready();
    tlp_valid               = 1'b1;
    tlp_typ                 = 2'b00;
    tlp_has_data            = 1'b1;
    tlp_len_dw              = LW'(12);
    receiver_overflow_error = 1'b0;
    chk_q.push_back('{typ: 2'b00, len: LW'(12)});
    @(posedge clk);
    #1;
    tlp_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_hdr[i]  = 0;
      m_data[i] = 0;
    end
    check("abort_ready", tlp_ready, 1);
    check("abort_done", tlp_done, 0);
    check_counters_zero("abort");
    repeat (2) @(posedge clk);
    #1;

    // Header counter wrap
    for (int i = 0; i < 4095; i++) send(2'b00, 0, 0, 0);
    drain();
    check("wrap_pre_p_hdr", p_rcv_hdr, 12'hFFF);
    send(2'b00, 0, 0, 0);
    drain();
    check("wrap_post_p_hdr", p_rcv_hdr, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      send(2'($urandom), 1'($urandom), $urandom_range(0, (1 << LW) - 1),
           ($urandom_range(0, 3) == 0));
    end
    drain();
    check("final_chk_q_empty", chk_q.size(), 0);
    check("final_done_q_empty", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
